pc_trace_checker: RTL and testbench

- Synthesizable, self-checking monitor that compares the sequence of PCs a PipelinedARMv8 core presents against an expected trace preloaded into an internal table.
- Sits beside the core and taps the fetch-stage PC and its valid strobe.
- Replaces manual inspection of printed PCs with a registered pass/fail verdict, a mismatch capture and a stall watchdog.
- Generalised in PC width, trace depth, timeout and stall-repeat handling.

---
 rtl/pc_trace_checker.sv | 170 +++++++++++++++++
 tb/tb_pc_trace_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_checker.sv
// Compares fetched PCs against a preloaded expected trace and raises a registered pass/fail verdict.
// Verdict is visible one edge after the deciding PC; stall bubbles and a watchdog are handled inside.
module pc_trace_checker #(
  parameter int PC_W        = 64,
  parameter int DEPTH       = 32,
  parameter int IDX_W       = 5,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16,
  parameter int SKIP_REPEAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_addr,
  input  logic [PC_W-1:0]  load_data,
  input  logic [IDX_W:0]   expected_count,
  input  logic             start,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [IDX_W-1:0] mismatch_index,
  output logic [PC_W-1:0]  mismatch_pc,
  output logic [IDX_W:0]   match_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam int             WD_W      = $clog2(TIMEOUT + 1);
  localparam int             TBL_N     = 2 ** IDX_W;
  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W + 1)'(DEPTH);
  localparam logic [WD_W-1:0] TIMEOUT_C = WD_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   match_q, match_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             last_vld_q, last_vld_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] mis_idx_q, mis_idx_d;
  logic [PC_W-1:0]  mis_pc_q, mis_pc_d;

  // Sized to the full index space so any idx_q value addresses a real entry.
  logic [PC_W-1:0] table_q [TBL_N];

  logic           tbl_we;
  logic           repeat_hit;
  logic [IDX_W:0] n_start;
  logic [IDX_W:0] idx_plus;

  assign tbl_we     = load_en && !reset && (state_q != S_RUN) && ({1'b0, load_addr} < DEPTH_C);
  assign repeat_hit = (SKIP_REPEAT != 0) && last_vld_q && (pc == last_pc_q);
  assign n_start    = (expected_count > DEPTH_C) ? DEPTH_C : expected_count;
  assign idx_plus   = {1'b0, idx_q} + (IDX_W + 1)'(1);

  always_ff @(posedge clock) begin
    if (tbl_we) begin
      table_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    match_d    = match_q;
    cyc_d      = cyc_q;
    wd_d       = wd_q;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    timeout_d  = timeout_q;
    mis_idx_d  = mis_idx_q;
    mis_pc_d   = mis_pc_q;

    if (state_q != S_RUN) begin
      if (start) begin
        n_d        = n_start;
        idx_d      = '0;
        match_d    = '0;
        cyc_d      = '0;
        wd_d       = '0;
        mis_idx_d  = '0;
        mis_pc_d   = '0;
        timeout_d  = 1'b0;
        last_vld_d = 1'b0;
        state_d    = (n_start == '0) ? S_PASS : S_RUN;
      end
    end else begin
      if (!(&cyc_q)) begin
        cyc_d = cyc_q + CNT_W'(1);
      end
      if (!pc_valid) begin
        wd_d = wd_q + WD_W'(1);
        if (wd_d == TIMEOUT_C) begin
          state_d   = S_FAIL;
          timeout_d = 1'b1;
          mis_idx_d = idx_q;
          mis_pc_d  = '0;
        end
      end else begin
        wd_d = '0;
        // A repeat of the last accepted PC is a pipeline stall, not a new fetch.
        if (!repeat_hit) begin
          if (pc == table_q[idx_q]) begin
            match_d    = match_q + (IDX_W + 1)'(1);
            last_pc_d  = pc;
            last_vld_d = 1'b1;
            idx_d      = idx_q + IDX_W'(1);
            if (idx_plus == n_q) begin
              state_d = S_PASS;
            end
          end else begin
            state_d   = S_FAIL;
            mis_idx_d = idx_q;
            mis_pc_d  = pc;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      match_q    <= '0;
      cyc_q      <= '0;
      wd_q       <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      timeout_q  <= 1'b0;
      mis_idx_q  <= '0;
      mis_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      cyc_q      <= cyc_d;
      wd_q       <= wd_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
      timeout_q  <= timeout_d;
      mis_idx_q  <= mis_idx_d;
      mis_pc_q   <= mis_pc_d;
    end
  end

  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass           = (state_q == S_PASS);
  assign fail           = (state_q == S_FAIL);
  assign timeout        = timeout_q;
  assign mismatch_index = mis_idx_q;
  assign mismatch_pc    = mis_pc_q;
  assign match_count    = match_q;
  assign cycle_count    = cyc_q;

endmodule

// File: tb/tb_pc_trace_checker.sv
// Drives two checker instances (stall-skip on / off) with directed and random traffic against a rule-level model.
module tb_pc_trace_checker;
  localparam int PC_W  = 64;
  localparam int DEPTH = 32;
  localparam int IDX_W = 6;
  localparam int TO    = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, load_en, start, pc_valid;
  logic [IDX_W-1:0] load_addr;
  logic [PC_W-1:0]  load_data, pc;
  logic [IDX_W:0]   expected_count;

  logic             busy_o [2];
  logic             done_o [2];
  logic             pass_o [2];
  logic             fail_o [2];
  logic             to_o   [2];
  logic [IDX_W-1:0] mi_o   [2];
  logic [PC_W-1:0]  mpc_o  [2];
  logic [IDX_W:0]   mc_o   [2];
  logic [15:0]      cyc_a;
  logic [3:0]       cyc_b;

  pc_trace_checker #(.PC_W(PC_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TO), .CNT_W(16), .SKIP_REPEAT(1)) dut_a (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .expected_count(expected_count), .start(start), .pc_valid(pc_valid), .pc(pc),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .timeout(to_o[0]),
    .mismatch_index(mi_o[0]), .mismatch_pc(mpc_o[0]), .match_count(mc_o[0]), .cycle_count(cyc_a)
  );

  pc_trace_checker #(.PC_W(PC_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .TIMEOUT(TO), .CNT_W(4), .SKIP_REPEAT(0)) dut_b (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .expected_count(expected_count), .start(start), .pc_valid(pc_valid), .pc(pc),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .timeout(to_o[1]),
    .mismatch_index(mi_o[1]), .mismatch_pc(mpc_o[1]), .match_count(mc_o[1]), .cycle_count(cyc_b)
  );

  // Reference model: one record per instance, updated from the rules once per clock.
  int          m_st [2];
  int          m_n [2], m_idx [2], m_match [2], m_cyc [2], m_wd [2], m_mi [2];
  logic [63:0] m_last [2], m_mpc [2];
  bit          m_lastv [2], m_to [2];
  logic [63:0] m_tbl [2][64];
  int          skip [2] = '{1, 0};
  int          cmax [2] = '{65535, 15};

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input int d);
    if (reset) begin
      m_st[d] = M_IDLE; m_n[d] = 0; m_idx[d] = 0; m_match[d] = 0; m_cyc[d] = 0; m_wd[d] = 0;
      m_last[d] = '0; m_lastv[d] = 0; m_to[d] = 0; m_mi[d] = 0; m_mpc[d] = '0;
      return;
    end
    if (m_st[d] != M_RUN) begin
      if (load_en && int'(load_addr) < DEPTH) m_tbl[d][load_addr] = load_data;
      if (start) begin
        m_n[d] = (int'(expected_count) > DEPTH) ? DEPTH : int'(expected_count);
        m_idx[d] = 0; m_match[d] = 0; m_cyc[d] = 0; m_wd[d] = 0;
        m_mi[d] = 0; m_mpc[d] = '0; m_to[d] = 0; m_lastv[d] = 0;
        m_st[d] = (m_n[d] == 0) ? M_PASS : M_RUN;
      end
    end else begin
      m_cyc[d] = (m_cyc[d] < cmax[d]) ? m_cyc[d] + 1 : cmax[d];
      if (!pc_valid) begin
        m_wd[d]++;
        if (m_wd[d] == TO) begin
          m_st[d] = M_FAIL; m_to[d] = 1; m_mi[d] = m_idx[d]; m_mpc[d] = '0;
        end
      end else begin
        m_wd[d] = 0;
        if (skip[d] == 1 && m_lastv[d] && pc == m_last[d]) begin
          // stall bubble: nothing to compare
        end else if (pc == m_tbl[d][m_idx[d]]) begin
          m_match[d]++; m_last[d] = pc; m_lastv[d] = 1; m_idx[d]++;
          if (m_idx[d] == m_n[d]) m_st[d] = M_PASS;
        end else begin
          m_st[d] = M_FAIL; m_mi[d] = m_idx[d]; m_mpc[d] = pc;
        end
      end
    end
  endtask

  task automatic compare(input int d);
    string p;
    p = (d == 0) ? "skip1" : "skip0";
    check_eq({p, " busy"}, busy_o[d], m_st[d] == M_RUN);
    check_eq({p, " done"}, done_o[d], m_st[d] == M_PASS || m_st[d] == M_FAIL);
    check_eq({p, " pass"}, pass_o[d], m_st[d] == M_PASS);
    check_eq({p, " fail"}, fail_o[d], m_st[d] == M_FAIL);
    check_eq({p, " timeout"}, to_o[d], m_to[d]);
    check_eq({p, " mismatch_index"}, mi_o[d], m_mi[d]);
    check_eq({p, " mismatch_pc"}, mpc_o[d], m_mpc[d]);
    check_eq({p, " match_count"}, mc_o[d], m_match[d]);
    check_eq({p, " cycle_count"}, (d == 0) ? {48'd0, cyc_a} : {60'd0, cyc_b}, m_cyc[d]);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle_inputs();
    reset = 0; load_en = 0; load_addr = '0; load_data = '0;
    expected_count = '0; start = 0; pc_valid = 0; pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1; cycle();
  endtask

  task automatic do_load(input int a, input logic [63:0] v);
    idle_inputs(); load_en = 1; load_addr = IDX_W'(a); load_data = v; cycle();
  endtask

  task automatic do_start(input int n);
    idle_inputs(); start = 1; expected_count = (IDX_W + 1)'(n); cycle();
  endtask

  task automatic do_pc(input bit v, input logic [63:0] p);
    idle_inputs(); pc_valid = v; pc = p; cycle();
  endtask

  logic [63:0] br [6] = '{64'h0, 64'h4, 64'h8, 64'h1C, 64'h20, 64'h28};

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) m_tbl[d][i] = '0;
    idle_inputs();
    do_reset();
    do_reset();
    check_eq("reset busy", busy_o[0], 0);
    check_eq("reset done", done_o[1], 0);

    for (int i = 0; i < DEPTH; i++) do_load(i, {$urandom, $urandom});
    for (int i = 0; i < 6; i++) do_load(i, br[i]);

    // Branch trace, with a stray start mid-run that must be ignored.
    do_start(6);
    for (int i = 0; i < 6; i++) begin
      idle_inputs(); pc_valid = 1; pc = br[i];
      if (i == 2) start = 1;
      cycle();
    end
    check_eq("branch pass", pass_o[0], 1);
    check_eq("branch match_count", mc_o[0], 6);
    check_eq("branch cycle_count", cyc_a, 6);

    // Wrong branch target at index 3.
    do_start(6);
    for (int i = 0; i < 4; i++) do_pc(1, (i == 3) ? 64'hC : br[i]);
    check_eq("wrong fail", fail_o[0], 1);
    check_eq("wrong mismatch_index", mi_o[0], 3);
    check_eq("wrong mismatch_pc", mpc_o[0], 64'hC);
    check_eq("wrong match_count", mc_o[0], 3);
    check_eq("wrong timeout", to_o[0], 0);

    // Stall repeats: skip instance passes, no-skip instance fails at index 2.
    do_start(3);
    do_pc(1, 0); do_pc(1, 4); do_pc(1, 4); do_pc(1, 4); do_pc(1, 8);
    check_eq("stall skip pass", pass_o[0], 1);
    check_eq("stall noskip fail", fail_o[1], 1);
    check_eq("stall noskip index", mi_o[1], 2);
    check_eq("stall noskip pc", mpc_o[1], 64'h4);

    // Watchdog.
    do_start(3);
    do_pc(1, 0);
    for (int i = 1; i <= TO; i++) begin
      do_pc(0, 0);
      if (i == TO - 1) check_eq("watchdog early", fail_o[0], 0);
    end
    check_eq("watchdog fail", fail_o[0], 1);
    check_eq("watchdog timeout", to_o[0], 1);
    check_eq("watchdog index", mi_o[0], 1);

    do_start(0);
    check_eq("zero count pass", pass_o[0], 1);

    // Clamp 40 -> 32; the narrow counter on the second instance saturates.
    do_start(40);
    for (int i = 0; i < DEPTH; i++) do_pc(1, m_tbl[0][i]);
    check_eq("clamp pass", pass_o[0], 1);
    check_eq("clamp match_count", mc_o[0], 32);
    check_eq("saturated cycle_count", cyc_b, 15);

    // Load during RUN must not disturb the table.
    do_start(3);
    idle_inputs(); load_en = 1; load_addr = 1; load_data = 64'hDEAD; pc_valid = 1; pc = 0; cycle();
    do_pc(1, 4); do_pc(1, 8);
    check_eq("load in run ignored", pass_o[0], 1);

    do_load(33, 64'hBAD);

    // Load and start together: the new entry is used.
    idle_inputs(); load_en = 1; load_addr = 0; load_data = 64'h100; start = 1; expected_count = 1; cycle();
    do_pc(1, 64'h100);
    check_eq("start+load pass", pass_o[0], 1);

    // Reset mid-run, then rerun the retained trace.
    do_load(0, 64'h0);
    do_start(6);
    do_pc(1, br[0]); do_pc(1, br[1]);
    do_reset();
    check_eq("midrun reset busy", busy_o[0], 0);
    check_eq("midrun reset match_count", mc_o[0], 0);
    do_start(6);
    for (int i = 0; i < 6; i++) do_pc(1, br[i]);
    check_eq("rerun pass", pass_o[0], 1);

    // Random traffic with small PC values so repeats and mismatches occur.
    for (int c = 0; c < 1500; c++) begin
      int k;
      idle_inputs();
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 12) begin
        load_en = 1;
        load_addr = IDX_W'($urandom_range(0, 40));
        load_data = 64'($urandom_range(0, 7) * 4);
      end
      if ($urandom_range(0, 99) < 8) begin
        start = 1;
        expected_count = (IDX_W + 1)'($urandom_range(0, 8));
      end
      pc_valid = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, 9);
      if (k < 6)      pc = m_tbl[0][m_idx[0]];
      else if (k < 8) pc = m_last[0];
      else            pc = 64'($urandom_range(0, 15) * 4);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
